// File: rtl/temp_mem_pkg.sv
// Shared constants and types for the scratch-memory burst arbiter.
package temp_mem_pkg;

   localparam int ADDR_W = 13;
   localparam int LEN_W  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic              owner;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  remaining;
   } burst_cmd_t;

   function automatic logic [1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/temp_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker: the pointer names the preferred requester.
module rr_arb2 (
   input  logic [1:0] request,
   input  logic       ptr,
   output logic [1:0] grant
);

   // Preferred requester wins when asserted, otherwise the other one.
   always_comb begin
      grant = 2'b00;
      case (ptr)
         1'b0: begin
            if (request[0]) begin
               grant = 2'b01;
            end else if (request[1]) begin
               grant = 2'b10;
            end else begin
               grant = 2'b00;
            end
         end
         1'b1: begin
            if (request[1]) begin
               grant = 2'b10;
            end else if (request[0]) begin
               grant = 2'b01;
            end else begin
               grant = 2'b00;
            end
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/temp_mem_arbiter.sv
// Burst arbiter sharing the single-port scratch memory between the operand
// loader (requester 0) and the matrix compute engine (requester 1).
module temp_mem_arbiter
   import temp_mem_pkg::*;
#(
   parameter int N = ADDR_W,
   parameter int L = LEN_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_write,
   input  logic [1:0][N-1:0]   req_base,
   input  logic [1:0][L-1:0]   req_len,
   output logic [1:0]          beat,
   input  logic [1:0][7:0]     wdata,
   output logic [7:0]          rdata,
   output logic [1:0]          rvalid,
   output logic [1:0]          done,
   output logic                mem_write_en,
   output logic [N-1:0]        mem_addr,
   output logic [7:0]          mem_data_in,
   input  logic [7:0]          mem_data_out
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   arb_state_e  state_r;
   logic        ptr_r;
   burst_cmd_t  cmd_r;
   logic [7:0]  rdata_r;
   logic [1:0]  rvalid_r;
   logic [1:0]  done_r;
   logic [1:0]  grant_s;
   logic        win_s;

   rr_arb2 u_rr_arb2 (
      .request (req_valid),
      .ptr     (ptr_r),
      .grant   (grant_s)
   );

   assign rdata  = rdata_r;
   assign rvalid = rvalid_r;
   assign done   = done_r;

   // Grant handshake and memory drive, all derived from the latched burst.
   always_comb begin
      win_s        = grant_s[1];
      req_ready    = 2'b00;
      beat         = 2'b00;
      mem_write_en = 1'b0;
      mem_addr     = {N{1'b0}};
      mem_data_in  = 8'h00;
      if ((state_r == IDLE) && !rst) begin
         req_ready = grant_s;
      end else begin
         req_ready = 2'b00;
      end
      if (state_r == BURST) begin
         beat     = owner_onehot(cmd_r.owner);
         mem_addr = cmd_r.addr;
         if (cmd_r.write) begin
            mem_write_en = 1'b1;
            mem_data_in  = wdata[cmd_r.owner];
         end else begin
            mem_write_en = 1'b0;
            mem_data_in  = 8'h00;
         end
      end else begin
         beat = 2'b00;
      end
   end

   // Arbitration FSM with command, read-data and completion registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         ptr_r    <= 1'b0;
         cmd_r    <= '{owner: 1'b0, write: 1'b0, addr: {ADDR_W{1'b0}}, remaining: {LEN_W{1'b0}}};
         rdata_r  <= 8'h00;
         rvalid_r <= 2'b00;
         done_r   <= 2'b00;
      end else begin
         rvalid_r <= 2'b00;
         done_r   <= 2'b00;
         case (state_r)
            IDLE: begin
               if (grant_s != 2'b00) begin
                  cmd_r.owner     <= win_s;
                  cmd_r.write     <= req_write[win_s];
                  cmd_r.addr      <= req_base[win_s];
                  cmd_r.remaining <= req_len[win_s];
                  ptr_r           <= ~win_s;
                  state_r         <= BURST;
               end
            end
            BURST: begin
               // Address wraps naturally at the top of the memory.
               cmd_r.addr      <= cmd_r.addr + ADDR_ONE;
               cmd_r.remaining <= cmd_r.remaining - LEN_ONE;
               if (!cmd_r.write) begin
                  rdata_r  <= mem_data_out;
                  rvalid_r <= owner_onehot(cmd_r.owner);
               end
               if (cmd_r.remaining == {LEN_W{1'b0}}) begin
                  done_r  <= owner_onehot(cmd_r.owner);
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_mem_arbiter.sv
// Self-checking bench: command queues drive both requesters, and a
// schedule-based model predicts every output cycle by cycle.
module tb_temp_mem_arbiter;
   import temp_mem_pkg::*;

   localparam int N = ADDR_W;
   localparam int L = LEN_W;
   localparam int MSIZE = 1 << N;

   typedef struct {
      bit          wr;
      logic [N-1:0] base;
      logic [L-1:0] len;
      int          not_before;
   } cmd_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid, req_ready, req_write, beat, rvalid, done;
   logic [1:0][N-1:0] req_base;
   logic [1:0][L-1:0] req_len;
   logic [1:0][7:0]  wdata;
   logic [7:0]       rdata, mem_data_in, mem_data_out;
   logic             mem_write_en;
   logic [N-1:0]     mem_addr;
   logic [7:0]       tb_mem [MSIZE];

   cmd_t cq0[$], cq1[$];
   logic [7:0] dq0[$], dq1[$];
   bit   have_rec, rec_owner, rec_wr, m_ptr;
   int   rec_t, rec_base, rec_len;
   logic [7:0] ref_mem [MSIZE];
   int   cyc, rst_beat;
   int   n_cmp, n_err, n_ready;
   int   n_rv [2], n_dn [2], n_bt [2];
   int   obs_grants[$], obs_rdata[$];

   temp_mem_arbiter #(.N(N), .L(L)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_base(req_base), .req_len(req_len),
      .beat(beat), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .done(done),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   assign mem_data_out = tb_mem[mem_addr];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MSIZE; i++) tb_mem[i] <= 8'h00;
      end else if (mem_write_en) begin
         tb_mem[mem_addr] <= mem_data_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
      chk({tag, "_count"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++) chk(tag, got[i], exp[i]);
   endtask

   function automatic bit q_has(input int r);
      return (r == 0) ? (cq0.size() > 0) : (cq1.size() > 0);
   endfunction

   function automatic cmd_t q_front(input int r);
      return (r == 0) ? cq0[0] : cq1[0];
   endfunction

   task automatic q_pop(input int r);
      if (r == 0) cq0.delete(0); else cq1.delete(0);
   endtask

   task automatic q_push(input int r, input bit wr, input int base, input int len, input int nb);
      cmd_t c;
      c.wr = wr; c.base = N'(base); c.len = L'(len); c.not_before = nb;
      if (r == 0) cq0.push_back(c); else cq1.push_back(c);
   endtask

   function automatic bit drained();
      return !q_has(0) && !q_has(1) && rst == 1'b0 && rst_beat < 0 &&
             (!have_rec || cyc >= rec_t + 2 + rec_len);
   endfunction

   task automatic model_reset();
      have_rec = 1'b0;
      m_ptr    = 1'b0;
      for (int i = 0; i < MSIZE; i++) ref_mem[i] = 8'h00;
      dq0.delete();
      dq1.delete();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req_ready"}, req_ready, 2'b00);
      chk({tag, "_beat"}, beat, 2'b00);
      chk({tag, "_rvalid"}, rvalid, 2'b00);
      chk({tag, "_done"}, done, 2'b00);
      chk({tag, "_rdata"}, rdata, 8'h00);
      chk({tag, "_mem_we"}, mem_write_en, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_din"}, mem_data_in, 8'h00);
   endtask

   task automatic step(input bit gen);
      bit in_burst, win;
      int k;
      cmd_t c;
      logic [1:0] e_ready, e_beat, e_rv, e_dn;
      logic e_we;
      logic [N-1:0] e_addr;
      logic [7:0] e_din, e_rd;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) rst = 1'b0;
      if (gen) begin
         for (int r = 0; r < 2; r++) begin
            if (!q_has(r) && $urandom_range(0, 3) == 0)
               q_push(r, 1'($urandom), ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : int'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4), cyc);
         end
      end
      in_burst = have_rec && cyc >= rec_t + 1 && cyc <= rec_t + 1 + rec_len;
      k = cyc - rec_t - 1;
      for (int r = 0; r < 2; r++) begin
         c = q_has(r) ? q_front(r) : c;
         if (q_has(r) && c.not_before <= cyc) begin
            req_valid[r] = 1'b1; req_write[r] = c.wr; req_base[r] = c.base; req_len[r] = c.len;
         end else begin
            req_valid[r] = 1'b0; req_write[r] = 1'($urandom);
            req_base[r] = N'($urandom); req_len[r] = L'($urandom);
         end
         wdata[r] = 8'($urandom);
         if (in_burst && rec_wr && int'(rec_owner) == r) begin
            if (r == 0 && dq0.size() > 0) wdata[r] = dq0.pop_front();
            if (r == 1 && dq1.size() > 0) wdata[r] = dq1.pop_front();
         end
      end
      if (rst_beat >= 0 && in_burst && k == rst_beat) begin
         rst = 1'b1;
         rst_beat = -1;
         @(negedge clk);
         check_reset("midrst");
         model_reset();
         return;
      end
      e_ready = 2'b00; e_beat = 2'b00; e_rv = 2'b00; e_dn = 2'b00;
      e_we = 1'b0; e_addr = '0; e_din = 8'h00; e_rd = 8'h00; win = 1'b0;
      if (in_burst) begin
         e_beat = 2'b01 << rec_owner;
         e_addr = N'((rec_base + k) % MSIZE);
         if (rec_wr) begin
            e_we = 1'b1;
            e_din = wdata[rec_owner];
         end
      end
      if (have_rec && !rec_wr && cyc >= rec_t + 2 && cyc <= rec_t + 2 + rec_len) begin
         e_rv = 2'b01 << rec_owner;
         e_rd = ref_mem[(rec_base + cyc - rec_t - 2) % MSIZE];
      end
      if (have_rec && cyc == rec_t + 2 + rec_len) e_dn = 2'b01 << rec_owner;
      if (!in_burst && req_valid != 2'b00) begin
         win = (req_valid == 2'b11) ? m_ptr : req_valid[1];
         e_ready = 2'b01 << win;
      end
      @(negedge clk);
      chk("req_ready", req_ready, e_ready);
      chk("beat", beat, e_beat);
      chk("mem_write_en", mem_write_en, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_data_in", mem_data_in, e_din);
      chk("rvalid", rvalid, e_rv);
      chk("done", done, e_dn);
      if (e_rv != 2'b00) chk("rdata", rdata, e_rd);
      for (int r = 0; r < 2; r++) begin
         n_rv[r] += int'(rvalid[r]); n_dn[r] += int'(done[r]); n_bt[r] += int'(beat[r]);
      end
      if (req_ready != 2'b00) begin
         n_ready++;
         obs_grants.push_back(int'(req_ready[1]));
      end
      if (rvalid != 2'b00) obs_rdata.push_back(int'(rdata));
      if (in_burst && rec_wr) ref_mem[e_addr] = wdata[rec_owner];
      if (e_ready != 2'b00) begin
         c = q_front(win);
         q_pop(win);
         have_rec = 1'b1; rec_t = cyc; rec_owner = win; rec_wr = c.wr;
         rec_base = int'(c.base); rec_len = int'(c.len); m_ptr = ~win;
      end
   endtask

   task automatic run_phase(input string name, input int budget, input bit gen);
      n_ready = 0;
      n_rv = '{0, 0}; n_dn = '{0, 0}; n_bt = '{0, 0};
      obs_grants.delete();
      obs_rdata.delete();
      for (int c = 0; c < budget; c++) begin
         step(gen);
         if (!gen && drained()) break;
      end
      if (!gen) chk({name, "_drain"}, drained(), 1'b1);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; rst_beat = -1;
      rst = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_base = '0; req_len = '0; wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("reset");

      // Write then read of the same range.
      dq0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      q_push(0, 1'b1, 'h010, 3, cyc + 1);
      q_push(1, 1'b0, 'h010, 3, cyc + 1);
      run_phase("wr_rd", 200, 1'b0);
      chk_seq("wr_rd_grants", obs_grants, '{0, 1});
      chk_seq("wr_rd_rdata", obs_rdata, '{'hA0, 'hA1, 'hA2, 'hA3});
      chk("wr_rd_beats0", n_bt[0], 4);
      chk("wr_rd_done1", n_dn[1], 1);
      chk("wr_rd_mem13", tb_mem['h013], 8'hA3);

      // Contention with requester 0 re-requesting.
      q_push(0, 1'b0, $urandom_range(0, MSIZE - 1), 2, cyc + 1);
      q_push(0, 1'b0, $urandom_range(0, MSIZE - 1), 1, cyc + 1);
      q_push(1, 1'b0, $urandom_range(0, MSIZE - 1), 2, cyc + 1);
      run_phase("contend", 200, 1'b0);
      chk_seq("contend_grants", obs_grants, '{0, 1, 0});

      // Address wrap-around.
      dq0 = '{8'h11, 8'h22, 8'h33, 8'h44};
      q_push(0, 1'b1, 'h1FFE, 3, cyc + 1);
      q_push(1, 1'b0, 'h1FFE, 3, cyc + 3);
      run_phase("wrap", 200, 1'b0);
      chk("wrap_1ffe", tb_mem['h1FFE], 8'h11);
      chk("wrap_1fff", tb_mem['h1FFF], 8'h22);
      chk("wrap_0000", tb_mem['h0000], 8'h33);
      chk("wrap_0001", tb_mem['h0001], 8'h44);
      chk_seq("wrap_rdata", obs_rdata, '{'h11, 'h22, 'h33, 'h44});

      // Maximum length read with a mid-burst request from requester 1.
      q_push(0, 1'b0, $urandom_range(0, MSIZE - 1), 255, cyc + 1);
      q_push(1, 1'b0, $urandom_range(0, MSIZE - 1), 0, cyc + 20);
      run_phase("maxlen", 400, 1'b0);
      chk("maxlen_beats0", n_bt[0], 256);
      chk("maxlen_rvalid0", n_rv[0], 256);
      chk("maxlen_done0", n_dn[0], 1);
      chk("maxlen_ready", n_ready, 2);

      // Reset at beat 2 of a len=7 write, requests pending across it.
      q_push(0, 1'b1, 'h100, 7, cyc + 1);
      q_push(0, 1'b0, 'h100, 1, cyc + 3);
      q_push(1, 1'b0, 'h100, 1, cyc + 3);
      rst_beat = 2;
      run_phase("midrst", 200, 1'b0);
      chk_seq("midrst_grants", obs_grants, '{0, 0, 1});
      chk("midrst_done0", n_dn[0], 1);
      chk("midrst_done1", n_dn[1], 1);
      chk_seq("midrst_rdata", obs_rdata, '{0, 0, 0, 0});

      // Random traffic, then drain.
      run_phase("random", 400, 1'b1);
      run_phase("drain", 3000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/temp_mem_arbiter.md
# temp_mem_arbiter

Burst-oriented arbiter that shares the single-port 8-bit scratch memory (SIZE bytes, combinational read, synchronous write) between two requesters: requester 0 is the operand loader and requester 1 is the matrix compute engine. It accepts one burst command at a time and grants round-robin. It drives the memory's write enable, address and write data, and returns registered read data and a completion pulse to the owning requester.

## Interface
- N, 13, address width; memory size is 2**N bytes
- L, 8, burst length field width; a burst is len+1 bytes, 1..2**L
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  [1:0]  burst command valid, one bit per requester
- req_ready  out  [1:0]  command accepted this cycle; one-hot or zero
- req_write  in  [1:0]  1 = write burst, 0 = read burst
- req_base  in  [1:0][N-1:0]  start address
- req_len  in  [1:0][L-1:0]  burst length minus one
- beat  out  [1:0]  owner's data beat occurs this cycle
- wdata  in  [1:0][7:0]  write byte, sampled in a beat cycle
- rdata  out  8  registered read byte
- rvalid  out  [1:0]  rdata is valid for this requester
- done  out  [1:0]  one-cycle pulse when the owner's burst completes
- mem_write_en  out  1  to memory write_en
- mem_addr  out  N  to memory addr
- mem_data_in  out  8  to memory data_in
- mem_data_out  in  8  from memory data_out, combinational on mem_addr

## Operation
- FSM states:
  - IDLE: no memory access. mem_write_en=0, mem_addr=0, mem_data_in=0.
  - BURST: one beat per cycle.
- IDLE arbitration:
  - Winner is chosen among asserted req_valid bits by round-robin with a 1-bit pointer. The pointer names the preferred requester and resets to 0.
  - req_ready[winner]=1 is combinational and asserts in the same cycle.
  - On acceptance: latch owner, write flag, cur_addr=base and remaining=len. Set pointer to ~owner. Go to BURST.
  - The command must stay stable while req_valid is high and not yet accepted.
- BURST, every cycle:
  - mem_addr=cur_addr and beat[owner]=1.
  - Write burst: mem_write_en=1, mem_data_in=wdata[owner].
  - Read burst: mem_write_en=0, mem_data_in=0. mem_data_out is registered into rdata, with rvalid[owner]=1 on the next cycle.
  - cur_addr increments modulo 2**N, so it wraps from 2**N-1 to 0.
  - remaining decrements. The beat where remaining==0 is the last beat; the next state is IDLE.
- done[owner] is a registered pulse, asserted the cycle after the last beat. For reads it is coincident with the last rvalid.
- req_ready stays 0 in BURST. Requests arriving mid-burst wait.
- A request from a non-owner in BURST is not lost. It competes at the next IDLE cycle.
- Reset, including mid-burst:
  - State=IDLE, pointer=0.
  - rdata=0, rvalid=0, done=0, beat=0, req_ready=0.
  - mem_write_en=0, mem_addr=0, mem_data_in=0.
  - An interrupted burst is abandoned with no done. Memory contents are cleared by the memory's own reset on the same rst.

## Timing
- Command accepted at cycle T: beats at T+1..T+1+len, done at T+2+len.
- For reads, rvalid follows each beat by exactly 1 cycle.
- Next acceptance is possible at T+2+len, in the same cycle as done. This gives a 1-cycle IDLE bubble between bursts.
- Throughput is one byte per cycle within a burst.
- Simultaneous req_valid=2'b11 in IDLE: the pointer holder wins and the pointer flips.
- A single persistent requester is granted back-to-back with the bubble only.
- Read of an address written earlier in the same or a prior burst returns the new value, because writes commit at the beat edge.

## Structure
- Package temp_mem_pkg holds:
  - ADDR_W (13) and LEN_W (8) constants
  - typedef enum logic {IDLE, BURST} arb_state_e
  - typedef struct for a latched burst command {owner, write, addr, remaining}
- Sub-module rr_arb2: 2-input round-robin picker. Inputs are request[1:0] and the pointer; output is a one-hot grant. It is purely combinational and has its own unit bench.
- The top contains the FSM, command registers, read-data register and done pulse.

## Test plan
- Single write then read:
  - Req0 writes base=0x010, len=3, wdata 0xA0..0xA3. Expect beat[0] for 4 cycles, done[0] at T+5.
  - Req1 reads the same range. Expect rdata 0xA0..0xA3 with rvalid[1] on consecutive cycles and done[1] coincident with the last rvalid.
- Contention: both req_valid high in IDLE after reset.
  - Req0 granted first, pointer flips, req1 granted at req0's done cycle.
  - Repeat with req0 re-requesting; req1 must win next.
- Wrap-around: req0 writes base=0x1FFE, len=3, data 11,22,33,44.
  - Bytes land at 0x1FFE, 0x1FFF, 0x0000, 0x0001. The read-back matches.
- Max length: len=0xFF read. Exactly 256 beats and rvalid pulses, one done.
  - req_ready stays low throughout despite req1 asserting mid-burst.
- Reset mid-burst: assert rst at beat 2 of a len=7 write.
  - All outputs return to reset values immediately. No done pulses.
  - After release, a new req1 command is accepted with pointer=0 semantics.
